// File: rtl/fix_conn_mgr.sv
// fix_conn_mgr: connection manager between the application API and the
// TOE/FIFO interface. Accepts connect/disconnect requests, issues one-cycle
// connect/disconnect commands, tracks TOE acknowledgements per host and
// abandons unanswered connection attempts after TIMEOUT_CYCLES WAIT cycles.
//
// Optional feature macro: FIX_CONN_RETRY_EN -- when defined, an expired
// attempt is reissued up to MAX_RETRY times before timeout_o is pulsed.
//
// Ports:
//   clk                    clock, rising edge
//   rst                    asynchronous active-low reset
//   connect_i/connect_to_host_i        application connect request + host
//   disconnect_i/disconnect_host_i     application disconnect request + host
//   connected_i/connected_host_addr_i  TOE acknowledgement + host
//   connect_req_o/connect_addr_o       one-cycle connect command + host (held)
//   disconnect_o/disconnect_host_num_o one-cycle disconnect command + host (held)
//   host_connected_o       per-host connected bitmap
//   busy_o                 high whenever the manager is not idle
//   timeout_o/timeout_host_o           one-cycle abandon pulse + host (held)
module fix_conn_mgr #(
  parameter int unsigned NUM_HOSTS      = 4,
  parameter int unsigned HOST_W         = $clog2(NUM_HOSTS),
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES),
  parameter int          MAX_RETRY      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 connect_i,
  input  logic [HOST_W-1:0]    connect_to_host_i,
  input  logic                 disconnect_i,
  input  logic [HOST_W-1:0]    disconnect_host_i,
  input  logic                 connected_i,
  input  logic [HOST_W-1:0]    connected_host_addr_i,
  output logic                 connect_req_o,
  output logic [HOST_W-1:0]    connect_addr_o,
  output logic                 disconnect_o,
  output logic [HOST_W-1:0]    disconnect_host_num_o,
  output logic [NUM_HOSTS-1:0] host_connected_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [HOST_W-1:0]    timeout_host_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISC} state_e;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  // Reject parameter sets the datapath cannot represent.
  if (NUM_HOSTS < 2 || TIMEOUT_CYCLES < 2 || MAX_RETRY < 0 ||
      HOST_W < $clog2(NUM_HOSTS) || TIMEOUT_W < $clog2(TIMEOUT_CYCLES)) begin : g_param_check
    $error("fix_conn_mgr: illegal parameter set");
  end

  state_e                 state_q, state_d;
  logic [HOST_W-1:0]      target_q, target_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_HOSTS-1:0]   host_conn_q, host_conn_d;
  logic                   conn_req_q, conn_req_d;
  logic [HOST_W-1:0]      conn_addr_q, conn_addr_d;
  logic                   disc_q, disc_d;
  logic [HOST_W-1:0]      disc_host_q, disc_host_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [HOST_W-1:0]      timeout_host_q, timeout_host_d;

`ifdef FIX_CONN_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    host_conn_d    = host_conn_q;
    conn_req_d     = 1'b0;
    conn_addr_d    = conn_addr_q;
    disc_d         = 1'b0;
    disc_host_d    = disc_host_q;
    timeout_d      = 1'b0;
    timeout_host_d = timeout_host_q;
`ifdef FIX_CONN_RETRY_EN
    retry_d        = retry_q;
`endif

    case (state_q)
      IDLE: begin
        // Disconnect has priority; requests for a host already in the
        // requested state are dropped.
        if (disconnect_i && host_conn_q[disconnect_host_i]) begin
          state_d                        = DISC;
          host_conn_d[disconnect_host_i] = 1'b0;
          disc_d                         = 1'b1;
          disc_host_d                    = disconnect_host_i;
        end else if (connect_i && !host_conn_q[connect_to_host_i]) begin
          state_d     = REQ;
          target_d    = connect_to_host_i;
          conn_req_d  = 1'b1;
          conn_addr_d = connect_to_host_i;
        end
      end

      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        // Saturating counter; a matching acknowledgement beats expiry.
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + TIMEOUT_W'(1);
        if (connected_i && (connected_host_addr_i == target_q)) begin
          host_conn_d[target_q] = 1'b1;
          state_d               = IDLE;
`ifdef FIX_CONN_RETRY_EN
          retry_d               = '0;
`endif
        end else if (cnt_q == CNT_LAST) begin
`ifdef FIX_CONN_RETRY_EN
          if (retry_q < RETRY_MAX) begin
            retry_d     = retry_q + RETRY_W'(1);
            state_d     = REQ;
            conn_req_d  = 1'b1;
            conn_addr_d = target_q;
          end else begin
            retry_d        = '0;
            state_d        = IDLE;
            timeout_d      = 1'b1;
            timeout_host_d = target_q;
          end
`else
          state_d        = IDLE;
          timeout_d      = 1'b1;
          timeout_host_d = target_q;
`endif
        end
      end

      DISC: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      target_q       <= '0;
      cnt_q          <= '0;
      host_conn_q    <= '0;
      conn_req_q     <= 1'b0;
      conn_addr_q    <= '0;
      disc_q         <= 1'b0;
      disc_host_q    <= '0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      timeout_host_q <= '0;
`ifdef FIX_CONN_RETRY_EN
      retry_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      host_conn_q    <= host_conn_d;
      conn_req_q     <= conn_req_d;
      conn_addr_q    <= conn_addr_d;
      disc_q         <= disc_d;
      disc_host_q    <= disc_host_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
      timeout_host_q <= timeout_host_d;
`ifdef FIX_CONN_RETRY_EN
      retry_q        <= retry_d;
`endif
    end
  end

  assign connect_req_o         = conn_req_q;
  assign connect_addr_o        = conn_addr_q;
  assign disconnect_o          = disc_q;
  assign disconnect_host_num_o = disc_host_q;
  assign host_connected_o      = host_conn_q;
  assign busy_o                = busy_q;
  assign timeout_o             = timeout_q;
  assign timeout_host_o        = timeout_host_q;

endmodule

// File: tb/tb_fix_conn_mgr.sv
// Testbench for fix_conn_mgr (NUM_HOSTS=4, TIMEOUT_CYCLES=8). Every cycle the
// DUT outputs are compared with a transaction-level reference model; directed
// steps add explicit checks for the scenarios of interest.
module tb_fix_conn_mgr;

  localparam int unsigned NH = 4;
  localparam int unsigned HW = 2;
  localparam int unsigned TO = 8;
  localparam int unsigned TW = 3;
`ifdef FIX_CONN_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          connect_i = 1'b0;
  logic [HW-1:0] connect_to_host_i = '0;
  logic          disconnect_i = 1'b0;
  logic [HW-1:0] disconnect_host_i = '0;
  logic          connected_i = 1'b0;
  logic [HW-1:0] connected_host_addr_i = '0;
  logic          connect_req_o;
  logic [HW-1:0] connect_addr_o;
  logic          disconnect_o;
  logic [HW-1:0] disconnect_host_num_o;
  logic [NH-1:0] host_connected_o;
  logic          busy_o;
  logic          timeout_o;
  logic [HW-1:0] timeout_host_o;

  always #5 clk = ~clk;

  fix_conn_mgr #(
    .NUM_HOSTS(NH), .HOST_W(HW), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(TW), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .connect_i(connect_i), .connect_to_host_i(connect_to_host_i),
    .disconnect_i(disconnect_i), .disconnect_host_i(disconnect_host_i),
    .connected_i(connected_i), .connected_host_addr_i(connected_host_addr_i),
    .connect_req_o(connect_req_o), .connect_addr_o(connect_addr_o),
    .disconnect_o(disconnect_o), .disconnect_host_num_o(disconnect_host_num_o),
    .host_connected_o(host_connected_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .timeout_host_o(timeout_host_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which hosts are up, how long the current attempt still
  // has to wait, how many reissues remain, and the one-cycle pulses.
  bit          m_conn [NH];
  int          m_wait_left;
  int          m_tries_left;
  bit          m_req, m_disc, m_to;
  logic [HW-1:0] m_target, m_addr, m_dhost, m_tohost;

  task automatic model_reset();
    for (int i = 0; i < int'(NH); i++) m_conn[i] = 1'b0;
    m_wait_left = 0; m_tries_left = 0;
    m_req = 1'b0; m_disc = 1'b0; m_to = 1'b0;
    m_target = '0; m_addr = '0; m_dhost = '0; m_tohost = '0;
  endtask

  task automatic model_step(bit c, logic [HW-1:0] ch, bit d, logic [HW-1:0] dh,
                            bit a, logic [HW-1:0] ah);
    bit nreq = 1'b0, ndisc = 1'b0, nto = 1'b0;
    if (m_req) begin
      m_wait_left = int'(TO);
    end else if (!m_disc) begin
      if (m_wait_left > 0) begin
        if (a && ah == m_target) begin
          m_conn[m_target] = 1'b1;
          m_wait_left = 0;
        end else begin
          m_wait_left--;
          if (m_wait_left == 0) begin
            if (m_tries_left > 0) begin
              m_tries_left--; nreq = 1'b1; m_addr = m_target;
            end else begin
              nto = 1'b1; m_tohost = m_target;
            end
          end
        end
      end else if (d && m_conn[dh]) begin
        m_conn[dh] = 1'b0; ndisc = 1'b1; m_dhost = dh;
      end else if (c && !m_conn[ch]) begin
        m_target = ch; m_addr = ch; nreq = 1'b1; m_tries_left = RETRIES;
      end
    end
    m_req = nreq; m_disc = ndisc; m_to = nto;
  endtask

  function automatic logic [13:0] model_out();
    logic busy = m_req | m_disc | (m_wait_left > 0);
    return {m_req, m_addr, m_disc, m_dhost,
            m_conn[3], m_conn[2], m_conn[1], m_conn[0], busy, m_to, m_tohost};
  endfunction

  function automatic logic [13:0] dut_out();
    return {connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o,
            host_connected_o, busy_o, timeout_o, timeout_host_o};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare all outputs.
  task automatic step(bit c, logic [HW-1:0] ch, bit d, logic [HW-1:0] dh,
                      bit a, logic [HW-1:0] ah);
    connect_i = c; connect_to_host_i = ch;
    disconnect_i = d; disconnect_host_i = dh;
    connected_i = a; connected_host_addr_i = ah;
    @(posedge clk);
    model_step(c, ch, d, dh, a, ah);
    #1;
    check("cycle", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("reset_outputs", 32'(dut_out()), 32'(14'd0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int req_cnt, last_req, to_idx, to_cnt;
    logic [HW-1:0] to_host;
    logic [NH-1:0] bm_after_stray;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_initial", 32'(dut_out()), 32'(14'd0));
    rst = 1'b1;

    // Some random traffic, then a reset in the middle of it.
    for (int i = 0; i < 20; i++)
      step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    apply_reset();

    // Connect host 2, acknowledge two cycles after the pulse.
    step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
    check("req_pulse", 32'(connect_req_o), 32'd1);
    check("req_addr", 32'(connect_addr_o), 32'd2);
    idle();
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2);
    check("bitmap_h2", 32'(host_connected_o), 32'h4);
    check("busy_after_ack", 32'(busy_o), 32'd0);

    // Host 1 attempt with a stray ack for host 3; count reissues and timeout.
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
    req_cnt = 1; last_req = 0; to_idx = -1; to_host = '0;
    bm_after_stray = '0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b0, 2'd0, 1'b0, 2'd0, (i == 3), 2'd3);
      if (i == 4) bm_after_stray = host_connected_o;
      if (connect_req_o) begin
        req_cnt++;
        check("retry_gap", 32'(i - last_req), 32'd9);
        last_req = i;
      end
      if (timeout_o) begin
        to_idx = i; to_host = timeout_host_o;
        break;
      end
    end
    check("stray_ack_ignored", 32'(bm_after_stray), 32'h4);
    check("req_pulses", 32'(req_cnt), 32'(RETRIES + 1));
    check("timeout_cycle", 32'(to_idx), 32'(9 * (RETRIES + 1)));
    check("timeout_host", 32'(to_host), 32'd1);
    idle();
    check("timeout_one_cycle", 32'(timeout_o), 32'd0);

    // Bring up host 0, then connect host 1 and disconnect host 0 together.
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0);
    check("bitmap_h0h2", 32'(host_connected_o), 32'h5);
    step(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0);
    check("disc_wins", 32'({disconnect_o, connect_req_o}), 32'b10);
    check("disc_host", 32'(disconnect_host_num_o), 32'd0);
    check("bitmap_after_disc", 32'(host_connected_o), 32'h4);
    step(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0);
    check("idle_after_disc", 32'(busy_o), 32'd0);
    step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0);
    check("connect_after_disc", 32'({connect_req_o, connect_addr_o}), 32'b101);
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1);
    check("bitmap_h1h2", 32'(host_connected_o), 32'h6);

    // Redundant requests are dropped.
    step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
    check("dup_connect", 32'({connect_req_o, busy_o}), 32'd0);
    step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0);
    check("dup_disconnect", 32'({disconnect_o, busy_o}), 32'd0);

    // Reset during WAIT cycle 5; no timeout afterwards, fresh connect works.
    step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) idle();
    check("in_wait", 32'(busy_o), 32'd1);
    apply_reset();
    check("bitmap_cleared", 32'(host_connected_o), 32'd0);
    to_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (timeout_o) to_cnt++;
    end
    check("no_timeout_after_reset", 32'(to_cnt), 32'd0);
    step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
    idle();
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3);
    check("fresh_connect", 32'(host_connected_o), 32'h8);

    // Randomized traffic, acks biased towards the outstanding host.
    for (int i = 0; i < 400; i++) begin
      logic [HW-1:0] ah;
      ah = ($urandom_range(0, 1) == 1) ? m_target : 2'($urandom_range(0, 3));
      step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0), ah);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
